// File: rtl/clock_enable_sequencer_pkg.sv
// Shared types and helpers for the clock-enable sequencer: FSM states and
// the ratio legality rule.
package clock_enable_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam int MIN_RATIO = 2;

  // Ratios below 2 cannot form a period with distinct high and low phases.
  function automatic logic ratio_legal(input logic [31:0] ratio);
    return ratio >= MIN_RATIO;
  endfunction

endpackage

// File: rtl/clock_enable_sequencer_if.sv
// Ratio configuration handshake between a host and the clock-enable sequencer.
interface clock_enable_sequencer_if #(
  parameter int W = 16
);
  logic         cfg_valid;
  logic [W-1:0] cfg_ratio;
  logic         cfg_ready;

  modport master (output cfg_valid, output cfg_ratio, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ratio, output cfg_ready);
endinterface

// File: rtl/clock_enable_sequencer_period_counter.sv
// W-bit period counter: counts 0..ratio-1 while running, flags the wrap and
// half-period points of the current ratio.
module period_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         run,
  input  logic [W-1:0] ratio,
  output logic         wrap,
  output logic         half
);

  logic [W-1:0] r_cnt;

  assign wrap = run && (r_cnt == ratio - W'(1));
  assign half = run && (r_cnt == (ratio >> 1) - W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (run)   r_cnt <= wrap ? '0 : r_cnt + W'(1);
  end

endmodule

// File: rtl/clock_enable_sequencer.sv
// Programmable clock-enable generator: runs a period counter at the ratio in
// force and swaps new ratios in only at a period boundary.
module clock_enable_sequencer
  import clock_enable_pkg::*;
#(
  parameter int W         = 16,
  parameter int DEFAULT_M = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  clock_enable_sequencer_if.slave  cfg,
  output logic                     cfg_err,
  output logic [W-1:0]             ratio_o,
  output logic                     running,
  output logic                     ce_o,
  output logic                     clk_o
);

  state_t       r_state;
  logic [W-1:0] r_staged;
  logic         w_hs, w_legal, w_take, w_bad;
  logic         w_wrap, w_half, w_clear;

  assign cfg.cfg_ready = (r_state != PENDING);
  assign running       = (r_state != IDLE);

  assign w_hs    = cfg.cfg_valid & cfg.cfg_ready;
  assign w_legal = ratio_legal(32'(cfg.cfg_ratio));
  assign w_take  = w_hs & w_legal;
  assign w_bad   = w_hs & ~w_legal;
  // Dropping enable restarts the next run from phase 0.
  assign w_clear = ~running | ~enable;

  period_counter #(.W(W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .run   (running),
    .ratio (ratio_o),
    .wrap  (w_wrap),
    .half  (w_half)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_staged <= '0;
      ratio_o  <= W'(DEFAULT_M);
      clk_o    <= 1'b0;
      ce_o     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= w_bad;
      ce_o    <= 1'b0;
      case (r_state)
        IDLE: begin
          clk_o <= 1'b0;
          if (w_take) ratio_o <= cfg.cfg_ratio;
          if (enable) r_state <= RUN;
        end
        RUN, PENDING: begin
          if (!enable) begin
            r_state <= IDLE;
            clk_o   <= 1'b0;
            if (r_state == PENDING) ratio_o <= r_staged;
            else if (w_take)        ratio_o <= cfg.cfg_ratio;
          end else begin
            if (w_wrap) begin
              ce_o  <= 1'b1;
              clk_o <= 1'b1;
            end else if (w_half) begin
              clk_o <= 1'b0;
            end
            // A handshake on a RUN wrap stages; the old ratio finishes this period.
            if (w_wrap && r_state == PENDING) begin
              ratio_o <= r_staged;
              r_state <= RUN;
            end else if (w_take) begin
              r_staged <= cfg.cfg_ratio;
              r_state  <= PENDING;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_clock_enable_sequencer;

  localparam int W  = 16;
  localparam int DM = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         cfg_err, running, ce_o, clk_o;
  logic [W-1:0] ratio_o;

  clock_enable_sequencer_if #(.W(W)) cfg_bus ();

  clock_enable_sequencer #(.W(W), .DEFAULT_M(DM)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .cfg     (cfg_bus),
    .cfg_err (cfg_err),
    .ratio_o (ratio_o),
    .running (running),
    .ce_o    (ce_o),
    .clk_o   (clk_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ce, ck, err, run, rdy;
    int   m;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: running flag, ratio in force, optional staged ratio, edges since
  // the current period began, and whether that period is the first after start.
  bit m_run, m_stg_v, m_first, m_ce, m_err;
  int m_m, m_stg, m_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t s;
    s.ce  = m_ce;
    s.ck  = m_run && !m_first && (m_n < m_m / 2);
    s.err = m_err;
    s.run = m_run;
    s.rdy = !(m_run && m_stg_v);
    s.m   = m_m;
    return s;
  endfunction

  task automatic model_reset();
    m_run = 0; m_stg_v = 0; m_first = 0; m_ce = 0; m_err = 0;
    m_m = DM; m_stg = 0; m_n = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input int r);
    bit rdy, hs, legal;
    rdy   = !(m_run && m_stg_v);
    hs    = v && rdy;
    legal = r >= 2;
    m_err = hs && !legal;
    m_ce  = 0;
    if (!m_run) begin
      if (hs && legal) m_m = r;
      if (en) begin m_run = 1; m_n = 0; m_first = 1; end
    end else if (!en) begin
      m_run = 0;
      if (m_stg_v)          m_m = m_stg;
      else if (hs && legal) m_m = r;
      m_stg_v = 0;
    end else begin
      if (m_n == m_m - 1) begin
        m_ce = 1; m_n = 0; m_first = 0;
        if (m_stg_v) begin m_m = m_stg; m_stg_v = 0; end
      end else begin
        m_n++;
      end
      if (hs && legal) begin m_stg_v = 1; m_stg = r; end
    end
  endtask

  // One clock of stimulus, driven mid-low-phase; expectation is for the next edge.
  task automatic step(input bit rst, input bit en, input bit v, input int r);
    @(negedge clk);
    #1;
    reset             = rst;
    enable            = en;
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_ratio = W'(r);
    if (rst) begin
      model_reset();
      #1;
      chk("rst_ce_o",    32'(ce_o),    0);
      chk("rst_clk_o",   32'(clk_o),   0);
      chk("rst_cfg_err", 32'(cfg_err), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_ratio_o", 32'(ratio_o), DM);
    end else begin
      model_step(en, v, r);
    end
    q.push_back(snap());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ce_o",      32'(ce_o),              32'(e.ce));
        chk("clk_o",     32'(clk_o),             32'(e.ck));
        chk("cfg_err",   32'(cfg_err),           32'(e.err));
        chk("running",   32'(running),           32'(e.run));
        chk("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(e.rdy));
        chk("ratio_o",   32'(ratio_o),           e.m);
      end
    end
  end

  initial begin : stim
    bit en_r;
    int r;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_ratio = '0;
    model_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Default ratio 64 free-running.
    repeat (140) step(0, 1, 0, 0);
    // Idle, program 5, run.
    step(0, 0, 0, 0);
    step(0, 0, 1, 5);
    repeat (20) step(0, 1, 0, 0);
    // Go idle with 8, restart, swap to 3 at counter 2.
    step(0, 0, 1, 8);
    repeat (3) step(0, 1, 0, 0);
    step(0, 1, 1, 3);
    repeat (20) step(0, 1, 0, 0);
    // Illegal ratios.
    step(0, 1, 1, 1);
    repeat (5) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    repeat (10) step(0, 1, 0, 0);
    // Stage 10, then drop enable while pending.
    step(0, 1, 1, 10);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (25) step(0, 1, 0, 0);
    // Reset while pending, then run at ratio 2.
    step(0, 1, 1, 9);
    repeat (3) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 2);
    repeat (12) step(0, 1, 0, 0);

    en_r = 1;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) en_r = !en_r;
      case ($urandom_range(0, 5))
        0:       r = 0;
        1:       r = 1;
        default: r = $urandom_range(2, 12);
      endcase
      step(($urandom_range(0, 599) == 0), en_r, ($urandom_range(0, 7) == 0), r);
    end
    step(0, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_enable_sequencer.md
# clock_enable_sequencer

Run-time programmable clock-enable generator and controller for the divided-clock domains of the FM receiver (decimator, audio output). It owns a divide-ratio register, starts and stops a period counter, and swaps in new ratios through a valid/ready handshake. Swaps take effect only at a period boundary, so `clk_o` and `ce_o` never produce runt pulses. Downstream stages consume `ce_o` as a one-cycle enable; `clk_o` is kept for external codec pins.

## Interface
- `W`, 16: counter and ratio width; legal ratio range 2..2^W-1.
- `DEFAULT_M`, 64: ratio loaded at reset; must be ≥2.

Clock is `clk`; reset is `reset`, asynchronous and active-high.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run request; level-sensitive.
- `cfg_valid` in 1: new ratio offered.
- `cfg_ratio` in W: offered ratio M.
- `cfg_ready` out 1: ratio can be accepted this cycle.
- `cfg_err` out 1: one-cycle pulse; the accepted ratio was <2 and was discarded.
- `ratio_o` out W: ratio currently in force.
- `running` out 1: high in RUN and PENDING.
- `ce_o` out 1: one-cycle strobe, once per period.
- `clk_o` out 1: divided clock, registered.

## Operation
- FSM states:
  - IDLE: counter held at 0; `clk_o` = 0; `ce_o` = 0.
  - RUN: counting.
  - PENDING: counting, with a new ratio staged.
- Transitions:
  - IDLE→RUN when `enable` = 1.
  - RUN→PENDING on handshake (`cfg_valid` & `cfg_ready`) with a legal ratio.
  - PENDING→RUN at the wrap edge (counter == M-1). At that edge, load the staged ratio into `ratio_o`, set counter to 0, and pulse `ce_o` for the completing period.
  - RUN/PENDING→IDLE when `enable` = 0. This is immediate: counter cleared, `clk_o` cleared, staged ratio applied to `ratio_o`.
- `cfg_ready` = 1 in IDLE and RUN, 0 in PENDING.
- Handshake in IDLE: a legal ratio loads `ratio_o` directly at the accepting edge.
- Illegal ratio (0 or 1): accepted (ready/valid complete), `cfg_err` pulses the next cycle, no state or ratio change.
- Counter in RUN/PENDING: 0..M-1, where M = `ratio_o`.
  - At counter == M-1: counter ← 0, `clk_o` ← 1, `ce_o` ← 1.
  - At counter == M/2-1 (integer division): `clk_o` ← 0.
  - Otherwise: `ce_o` ← 0.
- Result: `clk_o` is high while counter ∈ 0..M/2-1, i.e. floor(M/2) cycles high and ceil(M/2) low. Period is exactly M cycles.
- Simultaneous events:
  - Handshake on the same edge as a wrap in RUN: ratio is staged; the current wrap uses the old M. The new M applies from the following wrap.
  - `enable` = 0 together with a handshake in RUN: go to IDLE; the new ratio (if legal) goes into `ratio_o`.
  - `enable` = 0 on a wrap edge: IDLE wins; `ce_o` is not pulsed.
- Reset (any time, including mid-period or PENDING):
  - State IDLE; counter 0; staged ratio discarded.
  - `ratio_o` = `DEFAULT_M`.
  - `clk_o`, `ce_o`, `cfg_err` = 0.
  - `running` = 0; `cfg_ready` = 1 after reset deasserts.

## Timing
- All outputs are registered except `cfg_ready` and `running`, which are decoded from state.
- First `ce_o` comes exactly M cycles after the edge that enters RUN. After that, `ce_o` repeats every M cycles.
- `clk_o` stays low during the whole first period after start.
- Ratio change latency: from the accept edge to the next wrap using old M; then one full new period to the next `ce_o`.
- Restart after IDLE always begins with counter = 0 (fixed phase).

## Structure
- Package `clock_enable_pkg` holds:
  - `state_t` enum (IDLE, RUN, PENDING);
  - `localparam MIN_RATIO = 2`;
  - the ratio-legality function.
- One sub-module, `period_counter`: a W-bit counter with `clear`, `run` and `ratio` inputs, and `wrap`/`half` outputs. The FSM, staging register and output flops live in the top module.

## Test plan
- Reset, `DEFAULT_M` = 64, `enable` = 1 → first `ce_o` 64 cycles after RUN entry, then every 64; `clk_o` high for 32 and low for 32 cycles.
- In IDLE, write M = 5, then enable → `ce_o` period 5; `clk_o` 2 high / 3 low; `ratio_o` = 5.
- While running M = 8, write M = 3 at counter = 2 → `cfg_ready` drops; wrap at counter 7 still uses 8; following periods are 3; `cfg_ready` returns at the wrap.
- Write M = 1 and M = 0 → each pulses `cfg_err` for one cycle; `ratio_o` and `ce_o` spacing are unchanged.
- Drop `enable` in PENDING, with staged M = 10 → IDLE next edge; `clk_o` = 0; `ratio_o` = 10; re-enable → first `ce_o` after 10 cycles.
- Assert `reset` mid-period in PENDING → all outputs 0 immediately; `ratio_o` = 64; staged value lost; M = 2 after restart → `ce_o` every 2 cycles, `clk_o` toggles 1/1.
